// File: rtl/lc3_pkg.sv
// Shared LC-3 types and helpers for the branch-condition path.
package lc3_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned OFF_W  = 9;
    localparam int unsigned MASK_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } cc_state_t;

    localparam logic [MASK_W-1:0] NZP_NEG  = 3'b100;
    localparam logic [MASK_W-1:0] NZP_ZERO = 3'b010;
    localparam logic [MASK_W-1:0] NZP_POS  = 3'b001;

    // Sign-extend a 9-bit PC offset to a 16-bit address.
    function automatic logic [ADDR_W-1:0] sext9_16(input logic [OFF_W-1:0] off);
        return {{(ADDR_W-OFF_W){off[OFF_W-1]}}, off};
    endfunction

endpackage

// File: rtl/nzp_reg.sv
// Condition-code register: classifies the bus value on a load and holds one-hot NZP.
module nzp_reg
    import lc3_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                i_ld,
    input  logic [DATA_W-1:0]   i_bus,
    output logic [MASK_W-1:0]   o_nzp
);

    logic [MASK_W-1:0] r_nzp;
    logic [MASK_W-1:0] w_nzp_n;

    always_comb begin
        w_nzp_n = NZP_POS;
        if (i_bus[DATA_W-1])
            w_nzp_n = NZP_NEG;
        else if (i_bus == '0)
            w_nzp_n = NZP_ZERO;
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            r_nzp <= '0;
        else if (i_ld)
            r_nzp <= w_nzp_n;
    end

    assign o_nzp = r_nzp;

endmodule

// File: rtl/nzp_cc_unit.sv
// LC-3 condition-code producer: holds NZP and resolves BR enable/target via a 3-state FSM.
module nzp_cc_unit
    import lc3_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                LD_CC,
    input  logic [DATA_W-1:0]   Bus,
    input  logic                Eval_Req,
    input  logic [ADDR_W-1:0]   IR,
    input  logic [ADDR_W-1:0]   PC,
    output logic                N,
    output logic                Z,
    output logic                P,
    output logic                Eval_Ack,
    output logic                Ben,
    output logic [ADDR_W-1:0]   Target,
    output logic [CNT_W-1:0]    Br_Count,
    output logic [CNT_W-1:0]    Taken_Count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    cc_state_t          r_state;
    cc_state_t          w_state_n;
    logic               w_capture;
    logic               w_eval;

    logic [MASK_W-1:0]  w_nzp;
    logic [MASK_W-1:0]  r_mask;
    logic [OFF_W-1:0]   r_off9;
    logic [ADDR_W-1:0]  r_pc;
    logic               w_ben_n;
    logic [ADDR_W-1:0]  w_tgt_n;

    logic               r_eval_ack;
    logic               r_ben;
    logic [ADDR_W-1:0]  r_target;
    logic [CNT_W-1:0]   r_br_count;
    logic [CNT_W-1:0]   r_taken_count;

    logic               w_unused_ir;
    assign w_unused_ir = ^IR[ADDR_W-1:12];

    nzp_reg #(
        .DATA_W (DATA_W)
    ) u_nzp_reg (
        .Clk    (Clk),
        .Reset  (Reset),
        .i_ld   (LD_CC),
        .i_bus  (Bus),
        .o_nzp  (w_nzp)
    );

    always_ff @(posedge Clk) begin
        if (Reset)
            r_state <= IDLE;
        else
            r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        w_capture = 1'b0;
        w_eval    = 1'b0;
        case (r_state)
            IDLE: begin
                if (Eval_Req) begin
                    w_capture = 1'b1;
                    w_state_n = EVAL;
                end
            end
            EVAL: begin
                w_eval    = 1'b1;
                w_state_n = DONE;
            end
            DONE:    w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_mask <= '0;
            r_off9 <= '0;
            r_pc   <= '0;
        end else if (w_capture) begin
            r_mask <= IR[11:9];
            r_off9 <= IR[8:0];
            r_pc   <= PC;
        end
    end

    // NZP is read as registered, so an LD_CC during EVAL does not affect this branch.
    assign w_ben_n = |(r_mask & w_nzp);
    assign w_tgt_n = r_pc + sext9_16(r_off9);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_eval_ack    <= 1'b0;
            r_ben         <= 1'b0;
            r_target      <= '0;
            r_br_count    <= '0;
            r_taken_count <= '0;
        end else begin
            r_eval_ack <= w_eval;
            if (w_eval) begin
                r_ben    <= w_ben_n;
                r_target <= w_tgt_n;
                if (r_br_count != CNT_MAX)
                    r_br_count <= r_br_count + CNT_W'(1);
                if (w_ben_n && (r_taken_count != CNT_MAX))
                    r_taken_count <= r_taken_count + CNT_W'(1);
            end
        end
    end

    assign {N, Z, P}   = w_nzp;
    assign Eval_Ack    = r_eval_ack;
    assign Ben         = r_ben;
    assign Target      = r_target;
    assign Br_Count    = r_br_count;
    assign Taken_Count = r_taken_count;

endmodule
